// File: rtl/cpu_core_p.sv
// cpu_core_p: parametrised fetch/decode/execute core with external program and
// data memories (ready/valid wait states), hardware stack, maskable interrupt,
// HALT and a latched stack-fault state.
//
// state    | meaning
// FETCH    | take pending interrupt, or wait for instr_valid and latch IR
// DECODE   | split IR into opcode/operands, advance pc
// EXECUTE  | perform the instruction
// MEM_WAIT | hold data-memory strobe until mem_ready
// HALT     | idle until an enabled interrupt arrives
// FAULT    | stack over/underflow, left only by reset
module cpu_core_p #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    REG_COUNT   = 32,
    parameter int                    STACK_DEPTH = 16,
    parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR  = ADDR_WIDTH'(2)
) (
    input  logic                          clock,
    input  logic                          reset_s2,
    input  logic                          enable,
    output logic [ADDR_WIDTH-1:0]         instr_addr,
    input  logic [8+2*DATA_WIDTH-1:0]     instr_data,
    input  logic                          instr_valid,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic                          mem_we,
    output logic                          mem_re,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    input  logic                          mem_ready,
    input  logic                          irq,
    output logic                          irq_ack,
    input  logic [$clog2(REG_COUNT)-1:0]  dbg_sel,
    output logic [DATA_WIDTH-1:0]         dbg_reg,
    output logic [ADDR_WIDTH-1:0]         pc_out,
    output logic [7:0]                    op_code_out,
    output logic [4:0]                    sr_out,
    output logic                          halted,
    output logic                          fault
);

    localparam int RW  = $clog2(REG_COUNT);
    localparam int SW  = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
    localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = 8 + 2 * DATA_WIDTH;
    localparam int MSB = DATA_WIDTH - 1;

    localparam logic [2:0] S_FETCH    = 3'd0;
    localparam logic [2:0] S_DECODE   = 3'd1;
    localparam logic [2:0] S_EXECUTE  = 3'd2;
    localparam logic [2:0] S_MEM_WAIT = 3'd3;
    localparam logic [2:0] S_HALT     = 3'd4;
    localparam logic [2:0] S_FAULT    = 3'd5;

    localparam logic [7:0] OP_LDI  = 8'h01;
    localparam logic [7:0] OP_MOV  = 8'h02;
    localparam logic [7:0] OP_LD   = 8'h03;
    localparam logic [7:0] OP_ST   = 8'h04;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_SUB  = 8'h06;
    localparam logic [7:0] OP_ADDI = 8'h07;
    localparam logic [7:0] OP_SUBI = 8'h08;
    localparam logic [7:0] OP_AND  = 8'h09;
    localparam logic [7:0] OP_OR   = 8'h0A;
    localparam logic [7:0] OP_XOR  = 8'h0B;
    localparam logic [7:0] OP_CP   = 8'h0C;
    localparam logic [7:0] OP_CPI  = 8'h0D;
    localparam logic [7:0] OP_JMP  = 8'h0E;
    localparam logic [7:0] OP_BREQ = 8'h0F;
    localparam logic [7:0] OP_BRNE = 8'h10;
    localparam logic [7:0] OP_BRLT = 8'h11;
    localparam logic [7:0] OP_BRGE = 8'h12;
    localparam logic [7:0] OP_CALL = 8'h13;
    localparam logic [7:0] OP_RET  = 8'h14;
    localparam logic [7:0] OP_PUSH = 8'h15;
    localparam logic [7:0] OP_POP  = 8'h16;
    localparam logic [7:0] OP_SEI  = 8'h17;
    localparam logic [7:0] OP_CLI  = 8'h18;
    localparam logic [7:0] OP_RETI = 8'h19;
    localparam logic [7:0] OP_HALT = 8'h1A;

    logic [2:0]             r_state;
    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [4:0]             r_sr;        // {I, N, Z, V, C}
    logic [SPW-1:0]         r_sp;        // number of occupied stack entries
    logic [IW-1:0]          r_ir;
    logic [7:0]             r_op_code;
    logic [DATA_WIDTH-1:0]  r_op1;
    logic [DATA_WIDTH-1:0]  r_op2;
    logic [DATA_WIDTH-1:0]  r_regs [REG_COUNT];
    logic [SW-1:0]          r_stack [STACK_DEPTH];
    logic                   r_mem_we;
    logic                   r_mem_re;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [DATA_WIDTH-1:0]  r_mem_wdata;
    logic                   r_irq_ack;

    logic [RW-1:0]          w_rd_idx;
    logic [DATA_WIDTH-1:0]  w_ra;
    logic [DATA_WIDTH-1:0]  w_rb;
    logic [DATA_WIDTH-1:0]  w_operand;
    logic [DATA_WIDTH:0]    w_sum;
    logic [DATA_WIDTH:0]    w_diff;
    logic [DATA_WIDTH-1:0]  w_alu_res;
    logic                   w_alu_c;
    logic                   w_alu_v;
    logic [3:0]             w_alu_flags;
    logic                   w_full;
    logic                   w_empty;
    logic [SIW-1:0]         w_push_idx;
    logic [SIW-1:0]         w_top_idx;
    logic [SW-1:0]          w_top;
    logic                   w_take_irq;
    logic [ADDR_WIDTH-1:0]  w_target;

    assign w_rd_idx   = r_op1[RW-1:0];
    assign w_ra       = r_regs[w_rd_idx];
    assign w_rb       = r_regs[r_op2[RW-1:0]];
    assign w_full     = (r_sp == SPW'(STACK_DEPTH));
    assign w_empty    = (r_sp == '0);
    assign w_push_idx = r_sp[SIW-1:0];
    assign w_top_idx  = w_push_idx - SIW'(1);
    assign w_top      = r_stack[w_top_idx];
    assign w_take_irq = r_sr[4] & irq;
    assign w_target   = r_op1[ADDR_WIDTH-1:0];

    // Second ALU operand: immediate forms take op2, register forms take r[op2].
    always_comb begin
        w_operand = w_rb;
        case (r_op_code)
            OP_ADDI, OP_SUBI, OP_CPI: w_operand = r_op2;
            default:                  w_operand = w_rb;
        endcase
    end

    assign w_sum  = {1'b0, w_ra} + {1'b0, w_operand};
    assign w_diff = {1'b0, w_ra} - {1'b0, w_operand};

    // ALU result and C/V; logic ops keep C and clear V, and w_diff[MSB+1] is the borrow.
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = r_sr[0];
        w_alu_v   = 1'b0;
        case (r_op_code)
            OP_ADD, OP_ADDI: begin
                w_alu_res = w_sum[MSB:0];
                w_alu_c   = w_sum[DATA_WIDTH];
                w_alu_v   = (w_ra[MSB] == w_operand[MSB]) && (w_sum[MSB] != w_ra[MSB]);
            end
            OP_SUB, OP_SUBI, OP_CP, OP_CPI: begin
                w_alu_res = w_diff[MSB:0];
                w_alu_c   = w_diff[DATA_WIDTH];
                w_alu_v   = (w_ra[MSB] != w_operand[MSB]) && (w_diff[MSB] != w_ra[MSB]);
            end
            OP_AND:  w_alu_res = w_ra & w_rb;
            OP_OR:   w_alu_res = w_ra | w_rb;
            OP_XOR:  w_alu_res = w_ra ^ w_rb;
            default: w_alu_res = '0;
        endcase
    end

    assign w_alu_flags = {w_alu_res[MSB], (w_alu_res == '0), w_alu_v, w_alu_c};

    // Core sequencer: every architectural register advances only on enabled cycles.
    always_ff @(posedge clock) begin
        if (reset_s2) begin
            r_state     <= S_FETCH;
            r_pc        <= '0;
            r_sr        <= '0;
            r_sp        <= '0;
            r_ir        <= '0;
            r_op_code   <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_irq_ack   <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (enable) begin
            r_irq_ack <= 1'b0;
            case (r_state)
                S_FETCH, S_HALT: begin
                    if (w_take_irq) begin
                        if (w_full) begin
                            r_state <= S_FAULT;
                        end else begin
                            r_stack[w_push_idx] <= SW'(r_pc);
                            r_sp      <= r_sp + SPW'(1);
                            r_pc      <= IRQ_VECTOR;
                            r_sr[4]   <= 1'b0;
                            r_irq_ack <= 1'b1;
                            r_state   <= S_FETCH;
                        end
                    end else if ((r_state == S_FETCH) && instr_valid) begin
                        r_ir    <= instr_data;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_op_code <= r_ir[IW-1 -: 8];
                    r_op1     <= r_ir[2*DATA_WIDTH-1 -: DATA_WIDTH];
                    r_op2     <= r_ir[DATA_WIDTH-1:0];
                    r_pc      <= r_pc + ADDR_WIDTH'(1);
                    r_state   <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    r_state <= S_FETCH;
                    case (r_op_code)
                        OP_LDI: r_regs[w_rd_idx] <= r_op2;
                        OP_MOV: r_regs[w_rd_idx] <= w_rb;
                        OP_LD: begin
                            r_mem_addr <= r_op2[ADDR_WIDTH-1:0];
                            r_mem_re   <= 1'b1;
                            r_state    <= S_MEM_WAIT;
                        end
                        OP_ST: begin
                            r_mem_addr  <= w_target;
                            r_mem_wdata <= w_rb;
                            r_mem_we    <= 1'b1;
                            r_state     <= S_MEM_WAIT;
                        end
                        OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_AND, OP_OR, OP_XOR: begin
                            r_regs[w_rd_idx] <= w_alu_res;
                            r_sr[3:0]        <= w_alu_flags;
                        end
                        OP_CP, OP_CPI: r_sr[3:0] <= w_alu_flags;
                        OP_JMP:  r_pc <= w_target;
                        OP_BREQ: if (r_sr[2])            r_pc <= w_target;
                        OP_BRNE: if (!r_sr[2])           r_pc <= w_target;
                        OP_BRLT: if (r_sr[3] ^ r_sr[1])  r_pc <= w_target;
                        OP_BRGE: if (!(r_sr[3] ^ r_sr[1])) r_pc <= w_target;
                        OP_CALL, OP_PUSH: begin
                            if (w_full) begin
                                r_state <= S_FAULT;
                            end else begin
                                r_stack[w_push_idx] <= (r_op_code == OP_CALL) ? SW'(r_pc) : SW'(w_ra);
                                r_sp <= r_sp + SPW'(1);
                                if (r_op_code == OP_CALL) begin
                                    r_pc <= w_target;
                                end
                            end
                        end
                        OP_RET, OP_RETI, OP_POP: begin
                            if (w_empty) begin
                                r_state <= S_FAULT;
                            end else begin
                                r_sp <= r_sp - SPW'(1);
                                if (r_op_code == OP_POP) begin
                                    r_regs[w_rd_idx] <= w_top[DATA_WIDTH-1:0];
                                end else begin
                                    r_pc <= w_top[ADDR_WIDTH-1:0];
                                end
                                if (r_op_code == OP_RETI) begin
                                    r_sr[4] <= 1'b1;
                                end
                            end
                        end
                        OP_SEI:  r_sr[4]  <= 1'b1;
                        OP_CLI:  r_sr[4]  <= 1'b0;
                        OP_HALT: r_state  <= S_HALT;
                        default: ;
                    endcase
                end
                S_MEM_WAIT: begin
                    if (mem_ready) begin
                        if (r_mem_re) begin
                            r_regs[w_rd_idx] <= mem_rdata;
                        end
                        r_mem_we <= 1'b0;
                        r_mem_re <= 1'b0;
                        r_state  <= S_FETCH;
                    end
                end
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign instr_addr  = r_pc;
    assign pc_out      = r_pc;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_we      = r_mem_we;
    assign mem_re      = r_mem_re;
    assign irq_ack     = r_irq_ack;
    assign dbg_reg     = r_regs[dbg_sel];
    assign op_code_out = r_op_code;
    assign sr_out      = r_sr;
    assign halted      = (r_state == S_HALT);
    assign fault       = (r_state == S_FAULT);

endmodule
